// File: rtl/tx_stream_arbiter.sv
// Round-robin, packet-locking arbiter that shares one byte-wide transmit sink between NUM_REQ
// requester streams. A grant is released by a byte flagged last, or by a no-progress timeout.
module tx_stream_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_valid_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   last_g_q, last_g_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_found;
  logic               xfer;

  // Round-robin search: the requester after the last owner has the highest priority.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_l;
    pick       = last_g_q;
    pick_found = 1'b0;
    idx        = 0;
    idx_l      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_g_q) + i) % NUM_REQ;
      idx_l = IDX_W'(idx);
      if (!pick_found && req_valid_i[idx_l]) begin
        pick       = idx_l;
        pick_found = 1'b1;
      end
    end
  end

  assign xfer = (state_q == LOCKED) && req_valid_i[g_q] && tx_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the values from before the edge.
    if (reset_i) begin
      state_q   <= IDLE;
      g_q       <= '0;
      last_g_q  <= IDX_LAST;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_g_q  <= last_g_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    g_d       = g_q;
    last_g_d  = last_g_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    grant_d   = grant_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          state_d        = LOCKED;
          g_d            = pick;
          cnt_d          = '0;
          grant_d[pick]  = 1'b1;
        end
      end
      LOCKED: begin
        // A transfer on the threshold cycle wins over the timeout.
        if (xfer) begin
          cnt_d = '0;
          if (req_last_i[g_q]) begin
            state_d  = IDLE;
            last_g_d = g_q;
            grant_d  = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          last_g_d  = g_q;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output logic: zero-latency pass-through of the granted requester
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    if (state_q == LOCKED) begin
      tx_valid_o       = req_valid_i[g_q];
      req_ready_o[g_q] = tx_ready_i;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g_q == IDX_W'(k)) tx_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q == LOCKED);
  assign timeout_o = timeout_q;

endmodule

// File: doc/tx_stream_arbiter.md
# tx_stream_arbiter

Round-robin, packet-locking arbiter that shares one byte-wide transmit sink (the UART transmitter of the 6502 system) between several requesters, e.g. the 6502 UART peripheral and the USB CDC bridge. Each requester holds the grant until it transfers a byte flagged `last`, or until a no-progress timeout expires. Sits between the requester byte streams and the UART TX core, inside `main_6502`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, ≥2.
- `DATA_WIDTH`, 8: byte width.
- `TIMEOUT_CYCLES`, 5000000: cycles without a transfer before a held grant is revoked (100 ms at 50 MHz); ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: system clock.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in NUM_REQ: per-requester byte valid.
- `req_data_i` in NUM_REQ*DATA_WIDTH: requester k's byte in bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_last_i` in NUM_REQ: byte is the final byte of the packet.
- `req_ready_o` out NUM_REQ: per-requester ready.
- `tx_valid_o` out 1: byte valid to the sink.
- `tx_data_o` out DATA_WIDTH: byte to the sink.
- `tx_ready_i` in 1: sink accepts the byte this cycle.
- `grant_o` out NUM_REQ: one-hot grant, all-zero when idle.
- `busy_o` out 1: a grant is held.
- `timeout_o` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: IDLE and LOCKED. Registered state: grant index `g`, round-robin pointer `last_g`, timeout counter sized $clog2(TIMEOUT_CYCLES).
- IDLE:
  - If any `req_valid_i` is set, grant the first asserted requester searching from `last_g+1` modulo NUM_REQ, then go to LOCKED.
  - If none is set, stay in IDLE.
- LOCKED, datapath is combinational pass-through of requester `g`:
  - `tx_valid_o = req_valid_i[g]`
  - `tx_data_o = req_data_i[g]`
  - `req_ready_o[g] = tx_ready_i`
  - all other `req_ready_o` bits are 0.
- A transfer occurs when `tx_valid_o && tx_ready_i`.
- Transfer with `req_last_i[g]=1`: set `last_g<=g`, go to IDLE.
- Timeout counter:
  - Cleared on grant and on every transfer.
  - Otherwise increments each LOCKED cycle.
  - If it equals TIMEOUT_CYCLES-1 in a cycle with no transfer, then: `last_g<=g`, pulse `timeout_o`, go to IDLE.
  - Result: a silent grant lasts exactly TIMEOUT_CYCLES cycles.
- Simultaneous transfer and timeout threshold: the transfer wins, the counter clears, and no timeout occurs.
- A requester deasserting valid mid-packet keeps the grant; only `last` or timeout releases it.
- IDLE outputs: `tx_valid_o=0`, `tx_data_o=0`, `req_ready_o=0`, `grant_o=0`.
- Reset, including mid-packet:
  - State goes to IDLE; the packet is abandoned and nothing is replayed.
  - `last_g<=NUM_REQ-1`, so requester 0 wins first after reset.
  - Counter cleared.

## Timing
- Reset values: `grant_o=0`, `busy_o=0`, `timeout_o=0`, `tx_valid_o=0`, `tx_data_o=0`, `req_ready_o=0`.
- Request seen in IDLE at cycle n: `grant_o` and `busy_o` high at n+1; first transfer possible at n+1.
- Last-byte transfer at cycle m: `grant_o=0` at m+1 (IDLE cycle); next grant at m+2 at the earliest. Minimum gap between packets is one cycle.
- `timeout_o` is high for exactly one cycle: the first IDLE cycle after revocation.
- `grant_o`, `busy_o` and `timeout_o` are registered. The datapath adds zero latency.
- `req_ready_o` depends combinationally on `tx_ready_i`, with no other path. Requesters must not make valid depend on ready.

## Test plan
- Single requester, packet 0x41,0x42,0x43 (last on 0x43), `tx_ready_i=1`: grant at cycle 1, bytes on cycles 1-3, `grant_o=0` on cycle 4.
- Both requesters valid from reset, each sending 2-byte packets 0xA0,0xA1 / 0xB0,0xB1: sink sees A0,A1,B0,B1; the next contention round also starts with requester 0 (pointer rotates correctly).
- Backpressure: `tx_ready_i` toggles 1,0,0,1 during a 3-byte packet: no byte lost or duplicated; `req_ready_o` mirrors `tx_ready_i` only for the granted requester.
- Timeout with TIMEOUT_CYCLES=16: requester 1 sends one non-last byte and then drops valid. Grant is held 16 cycles after the transfer, then `timeout_o` pulses once, and requester 0 (pending) is granted the next cycle.
- Threshold collision: transfer lands exactly on the cycle the counter hits 15 (TIMEOUT_CYCLES=16): no `timeout_o`, grant kept.
- Reset asserted mid-packet while requester 1 is granted: next cycle all outputs are 0; with both requesting afterwards, requester 0 is granted first.
